// File: rtl/neuron_stream_pe_if.sv
// Stream bundle between the layer sequencer and the neuron PE.
// Handshake: a transfer happens on a rising clk edge when both valid and ready
// are high; the source holds valid and its payload stable until that edge, and
// ready may depend on the sink's state but never on valid.
//   input beats : in_valid/in_ready carrying in_data/in_weight (sequencer -> PE)
//   results     : out_valid/out_ready carrying out_data/sat_flag (PE -> consumer)
interface neuron_stream_pe_if #(
    parameter int LANES     = 4,
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_W   = 8,
    parameter int WIDTH_OUT = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*WIDTH_IN-1:0]   in_data;
    logic [LANES*WIDTH_W-1:0]    in_weight;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH_OUT-1:0]        out_data;
    logic                        sat_flag;

    // Sequencer / consumer side.
    modport master (
        output in_valid, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_data, sat_flag
    );

    // Processing element side.
    modport slave (
        input  in_valid, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/neuron_stream_pe.sv
// Streaming neuron processing element: multiplies LANES data/weight pairs per
// accepted beat, accumulates IN_SIZE products, adds a bias and then applies
// optional ReLU, an arithmetic right shift and saturation to WIDTH_OUT.
// Lanes whose element index is at or beyond IN_SIZE (final beat only) are
// masked to zero, so IN_SIZE need not be a multiple of LANES.
// state_dbg exposes the FSM state: 0=IDLE 1=ACC 2=FINAL 3=HOLD.
module neuron_stream_pe #(
    parameter int IN_SIZE   = 196,
    parameter int LANES     = 4,
    parameter int WIDTH_IN  = 8,
    parameter int IN_SIGNED = 0,
    parameter int WIDTH_W   = 8,
    parameter int WIDTH_B   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int WIDTH_OUT = 16,
    parameter int SHIFT_W   = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      relu_en,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic signed [WIDTH_B-1:0] bias,
    output logic                      busy,
    output logic [1:0]                state_dbg,
    neuron_stream_pe_if.slave         s
);

    localparam int BEATS = (IN_SIZE + LANES - 1) / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = WIDTH_IN + WIDTH_W + 1;

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        $signed({{(ACC_WIDTH-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FINAL = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_next;

    logic signed [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]            beat_cnt;
    logic                        relu_q;
    logic [SHIFT_W-1:0]          shift_q;
    logic signed [WIDTH_B-1:0]   bias_q;
    logic [WIDTH_OUT-1:0]        out_data_q;
    logic                        sat_q;

    logic                        beat_hs;
    logic                        last_beat;
    logic signed [ACC_WIDTH-1:0] lane_prod [LANES];
    logic signed [ACC_WIDTH-1:0] beat_sum;
    logic signed [ACC_WIDTH-1:0] biased;
    logic signed [ACC_WIDTH-1:0] relu_v;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [WIDTH_OUT-1:0]        out_next;
    logic                        sat_next;

    assign beat_hs   = (state == ACC) && s.in_valid;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

    // Per-lane product with data extension and tail masking.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH_IN-1:0]       d_raw;
        logic signed [WIDTH_IN:0]  d_ext;
        logic signed [WIDTH_W-1:0] w_k;
        logic signed [PROD_W-1:0]  p_k;
        logic                      lane_en;

        assign d_raw   = s.in_data[(k+1)*WIDTH_IN-1 -: WIDTH_IN];
        assign d_ext   = (IN_SIGNED != 0) ? $signed({d_raw[WIDTH_IN-1], d_raw})
                                          : $signed({1'b0, d_raw});
        assign w_k     = $signed(s.in_weight[(k+1)*WIDTH_W-1 -: WIDTH_W]);
        assign p_k     = d_ext * w_k;
        assign lane_en = (32'(beat_cnt) * 32'(LANES) + 32'(k)) < 32'(IN_SIZE);
        assign lane_prod[k] = lane_en ? ACC_WIDTH'(p_k) : '0;
    end

    // Sum of all lane products for the current beat (wraps at ACC_WIDTH).
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum = beat_sum + lane_prod[k];
        end
    end

    // Bias, ReLU, requantising shift and saturation on the registered accumulator.
    always_comb begin
        biased   = acc + ACC_WIDTH'(bias_q);
        relu_v   = (relu_q && biased[ACC_WIDTH-1]) ? '0 : biased;
        shifted  = relu_v >>> shift_q;
        out_next = shifted[WIDTH_OUT-1:0];
        sat_next = 1'b0;
        if (shifted > OUT_MAX) begin
            out_next = OUT_MAX[WIDTH_OUT-1:0];
            sat_next = 1'b1;
        end else if (shifted < OUT_MIN) begin
            out_next = OUT_MIN[WIDTH_OUT-1:0];
            sat_next = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and state-decoded outputs.
    always_comb begin
        state_next  = state;
        s.in_ready  = 1'b0;
        s.out_valid = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                s.in_ready = 1'b1;
                if (beat_hs && last_beat) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                state_next = HOLD;
            end
            HOLD: begin
                s.out_valid = 1'b1;
                if (s.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: configuration latch, accumulation and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            beat_cnt   <= '0;
            relu_q     <= 1'b0;
            shift_q    <= '0;
            bias_q     <= '0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        relu_q   <= relu_en;
                        shift_q  <= shift;
                        bias_q   <= bias;
                        acc      <= '0;
                        beat_cnt <= '0;
                    end
                end
                ACC: begin
                    if (beat_hs) begin
                        acc      <= acc + beat_sum;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                FINAL: begin
                    out_data_q <= out_next;
                    sat_q      <= sat_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign s.out_data = out_data_q;
    assign s.sat_flag = sat_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_neuron_stream_pe.sv
// Directed bench for neuron_stream_pe in a small configuration
// (IN_SIZE=5, LANES=2, WIDTH_OUT=8) with an element-level reference model.
module tb_neuron_stream_pe;

    localparam int IN_SIZE   = 5;
    localparam int LANES     = 2;
    localparam int WIDTH_IN  = 8;
    localparam int WIDTH_W   = 8;
    localparam int WIDTH_OUT = 8;
    localparam int BEATS     = 3;
    localparam int EXP_W     = WIDTH_OUT + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              start = 1'b0;
    logic              relu_en = 1'b0;
    logic [4:0]        shift = '0;
    logic signed [7:0] bias = '0;
    logic              busy;
    logic [1:0]        state_dbg;

    neuron_stream_pe_if #(
        .LANES(LANES), .WIDTH_IN(WIDTH_IN), .WIDTH_W(WIDTH_W), .WIDTH_OUT(WIDTH_OUT)
    ) ifc ();

    neuron_stream_pe #(
        .IN_SIZE(IN_SIZE), .LANES(LANES), .WIDTH_IN(WIDTH_IN), .IN_SIGNED(0),
        .WIDTH_W(WIDTH_W), .WIDTH_B(8), .ACC_WIDTH(32), .WIDTH_OUT(WIDTH_OUT),
        .SHIFT_W(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .shift(shift), .bias(bias), .busy(busy), .state_dbg(state_dbg), .s(ifc)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];   // {sat_flag, out_data}

    int stim_d [IN_SIZE];
    int stim_w [IN_SIZE];
    int pad_d = 0;
    int pad_w = 0;

    function automatic void check(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    // Reference: dot product over the IN_SIZE elements, 32-bit wrap, bias,
    // optional ReLU, floor division by 2^shift, clamp to the signed output range.
    function automatic logic [EXP_W-1:0] model(input int b, input bit r, input int sh);
        longint v = 0;
        logic signed [31:0] w32;
        bit sat = 0;
        logic [7:0] o;
        for (int i = 0; i < IN_SIZE; i++) v += longint'(stim_d[i]) * longint'(stim_w[i]);
        w32 = v[31:0];
        v = longint'(w32) + longint'(b);
        w32 = v[31:0];
        v = longint'(w32);
        if (r && v < 0) v = 0;
        v = v >>> sh;
        if (v > 127) begin v = 127; sat = 1; end
        else if (v < -128) begin v = -128; sat = 1; end
        o = v[7:0];
        return {sat, o};
    endfunction

    task automatic set_stim(input int d, input int w, input int pd, input int pw);
        for (int i = 0; i < IN_SIZE; i++) begin
            stim_d[i] = d;
            stim_w[i] = w;
        end
        pad_d = pd;
        pad_w = pw;
    endtask

    task automatic drive_beat(input int bt);
        int e;
        for (int k = 0; k < LANES; k++) begin
            e = bt * LANES + k;
            ifc.in_data[k*WIDTH_IN +: WIDTH_IN]  = (e < IN_SIZE) ? 8'(stim_d[e]) : 8'(pad_d);
            ifc.in_weight[k*WIDTH_W +: WIDTH_W]  = (e < IN_SIZE) ? 8'(stim_w[e]) : 8'(pad_w);
        end
        ifc.in_valid = 1'b1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset && ifc.out_valid) begin
            check("result_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("out_data", $signed(ifc.out_data), $signed(exp_q[0][WIDTH_OUT-1:0]));
                check("sat_flag", ifc.sat_flag, exp_q[0][WIDTH_OUT]);
                check("in_ready_in_hold", ifc.in_ready, 0);
            end
        end
    end

    // ---------------- driver ----------------
    // Called on a negative edge; returns on a negative edge with the DUT idle.
    task automatic do_op(input string nm, input int b, input bit r, input int sh,
                         input bit toggle, input int hold_cyc, input bit poke_start);
        int n;
        int start_cyc;
        logic [EXP_W-1:0] e;
        e = model(b, r, sh);
        exp_q.push_back(e);
        start = 1'b1; relu_en = r; shift = sh[4:0]; bias = b[7:0];
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        check({nm, "_busy_acc"}, busy, 1);
        for (int bt = 0; bt < BEATS; bt++) begin
            if (toggle && bt > 0) begin
                ifc.in_valid = 1'b0;
                @(negedge clk);
            end
            drive_beat(bt);
            n = 0;
            while (!ifc.in_ready && n < 20) begin @(negedge clk); n++; end
            if (!ifc.in_ready) check({nm, "_in_ready_timeout"}, 0, 1);
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        n = 0;
        while (!ifc.out_valid && n < 50) begin @(negedge clk); n++; end
        check({nm, "_out_valid_seen"}, ifc.out_valid, 1);
        if (!toggle) check({nm, "_latency"}, cyc - start_cyc, BEATS + 1);
        ifc.out_ready = 1'b0;
        for (int i = 0; i < hold_cyc; i++) begin
            start = (poke_start && i == 1);
            ifc.in_valid = 1'b1;
            check({nm, "_hold_valid"}, ifc.out_valid, 1);
            check({nm, "_hold_in_ready"}, ifc.in_ready, 0);
            @(negedge clk);
        end
        start = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        check({nm, "_accepted"}, ifc.out_valid, 0);
        check({nm, "_idle"}, busy, 0);
        check({nm, "_data_retained"}, $signed(ifc.out_data), $signed(e[WIDTH_OUT-1:0]));
        void'(exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [EXP_W-1:0] m;
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_weight = '0; ifc.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", ifc.in_ready, 0);
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_out_data", ifc.out_data, 0);
        check("rst_sat_flag", ifc.sat_flag, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // Hand-computed pins for the reference model.
        set_stim(1, 1, 0, 0);    m = model(0, 0, 0);  check("pin_ones", $signed(m[7:0]), 5);
        set_stim(1, -1, 0, 0);   m = model(-3, 0, 0); check("pin_neg", $signed(m[7:0]), -8);
                                 m = model(-3, 1, 0); check("pin_relu", $signed(m[7:0]), 0);
        set_stim(60, 1, 0, 0);   m = model(0, 0, 0);  check("pin_sat_hi", $signed(m[7:0]), 127);
                                                      check("pin_sat_hi_flag", m[8], 1);
                                 m = model(0, 0, 2);  check("pin_shift2", $signed(m[7:0]), 75);
                                                      check("pin_shift2_flag", m[8], 0);
        set_stim(60, -1, 0, 0);  m = model(0, 0, 0);  check("pin_sat_lo", $signed(m[7:0]), -128);

        set_stim(1, 1, 0, 0);      do_op("ones", 0, 0, 0, 0, 2, 0);
        set_stim(1, 1, 100, 100);  do_op("masked", 0, 0, 0, 0, 1, 0);
        set_stim(1, -1, 0, 0);     do_op("neg_bias", -3, 0, 0, 0, 0, 0);
                                   do_op("relu", -3, 1, 0, 0, 0, 0);
        set_stim(60, 1, 0, 0);     do_op("sat_hi", 0, 0, 0, 0, 1, 0);
                                   do_op("shift2", 0, 0, 2, 0, 1, 0);
        set_stim(60, -1, 0, 0);    do_op("sat_lo", 0, 0, 0, 0, 1, 0);
        set_stim(1, 1, 0, 0);      do_op("stall_hold", 0, 0, 0, 1, 5, 1);

        // Abort after two of three beats; no result may follow.
        set_stim(7, 3, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive_beat(0); @(negedge clk);
        drive_beat(1); @(negedge clk);
        ifc.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_in_ready", ifc.in_ready, 0);
        check("abort_out_valid", ifc.out_valid, 0);
        check("abort_out_data", ifc.out_data, 0);
        check("abort_busy", busy, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_still_idle", busy, 0);
        set_stim(1, 1, 0, 0);      do_op("after_abort", 0, 0, 0, 0, 1, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neuron_stream_pe.md
Name: neuron_stream_pe

Overview:
- Parametrised streaming neuron processing element; successor to the single-lane neuron used in the dense layers.
- Consumes LANES input/weight pairs per beat over a valid/ready handshake and accumulates IN_SIZE products.
- Adds a run-time bias, then applies optional ReLU, arithmetic right-shift requantisation and saturation to WIDTH_OUT.
- Sits between the layer sequencer (weight/pixel streamers) and the next layer's activation buffer.

Parameters:
- IN_SIZE, 196, number of input elements per neuron evaluation (≥1).
- LANES, 4, parallel multiply lanes per beat (≥1); IN_SIZE need not be a multiple.
- WIDTH_IN, 8, width of each input element.
- IN_SIGNED, 0, 1 = inputs signed; 0 = inputs unsigned (zero-extended).
- WIDTH_W, 8, signed weight width.
- WIDTH_B, 8, signed bias width.
- ACC_WIDTH, 32, signed accumulator width.
- WIDTH_OUT, 16, signed output width (≤ ACC_WIDTH).
- SHIFT_W, 5, width of run-time shift amount.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins an evaluation when in IDLE, ignored otherwise
- relu_en  in  1  ReLU enable, sampled with start
- shift  in  SHIFT_W  arithmetic right-shift amount, sampled with start
- bias  in  WIDTH_B  signed bias, sampled with start
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_data  in  LANES*WIDTH_IN  lane k at bits [(k+1)*WIDTH_IN-1 -: WIDTH_IN]
- in_weight  in  LANES*WIDTH_W  lane k at bits [(k+1)*WIDTH_W-1 -: WIDTH_W]
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  result consumed when out_valid & out_ready
- out_data  out  WIDTH_OUT  signed requantised result
- sat_flag  out  1  result was clamped; qualified by out_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, accumulator=0, beat counter=0, in_ready=0, out_valid=0, out_data=0, sat_flag=0, busy=0. Reset asserted in any state aborts the operation; no partial result is emitted.
- BEATS = ceil(IN_SIZE/LANES). Element index of lane k in beat b = b*LANES+k.
- IDLE: in_ready=0. When start=1: latch bias, relu_en, shift; clear accumulator and beat counter; go to ACC.
- ACC: in_ready=1. On each handshake:
  - acc += sum over lanes of data_k*weight_k, where lanes with index ≥ IN_SIZE contribute 0 (masked, final beat only).
  - Data is sign- or zero-extended per IN_SIGNED; weights are signed. Accumulation wraps modulo 2^ACC_WIDTH.
  - Counter increments; on the handshake of beat BEATS-1, go to FINAL.
  - in_valid low stalls without state change.
- FINAL (1 cycle, in_ready=0), computed on the registered accumulator:
  - v = acc + sign-extended bias (ACC_WIDTH wrap).
  - If relu_en and v<0: v=0.
  - v = v >>> shift (arithmetic shift, truncation toward −inf).
  - Clamp v to [−2^(WIDTH_OUT−1), 2^(WIDTH_OUT−1)−1]; sat_flag=1 iff clamped.
  - Register out_data and sat_flag; set out_valid; go to HOLD.
- HOLD: out_valid=1; out_data and sat_flag stable; in_ready=0; start ignored. When out_ready=1: out_valid←0 next edge, go to IDLE. out_data retains its last value after acceptance.
- Latency: with no stalls, out_valid is high BEATS+1 edges after the start edge. Minimum back-to-back period is BEATS+3 cycles.
- in_valid in IDLE/FINAL/HOLD is ignored; no beat is consumed.

Test Plan:
- IN_SIZE=5, LANES=2, all data=1, weights=1, bias=0, shift=0, relu off, continuous in_valid -> out_data=5, out_valid high 4 edges after start, sat_flag=0.
- Same config, final beat lane1 data=100, weight=100 -> masked; out_data=5, not 10005.
- Data=1, weights=−1 (sum −5), bias=−3: relu off -> out_data=−8; relu on -> out_data=0.
- WIDTH_OUT=8, sum=300, bias=0: shift=0 -> out_data=127, sat_flag=1; shift=2 -> out_data=75, sat_flag=0. Sum=−300, shift=0 -> −128, sat_flag=1.
- in_valid toggled every other cycle; out_ready low 5 cycles; start pulsed during HOLD -> result unchanged (5), out_data stable while held, in_ready=0 in HOLD, second start ignored.
- Reset asserted after 2 of 3 beats, then a fresh start with all-ones stimulus -> out_data=5, no residue; out_valid never asserts for the aborted operation.
